// File: rtl/divergence_stack.sv
// Per-warp SIMT divergence stack: tracks active masks, defers not-taken paths, redirects fetch on pop.
// Optional DIVSTACK_OVERFLOW_FLAG_EN adds a sticky overflow flag for dropped pushes.
module divergence_stack #(
    parameter int NumWarps   = 8,
    parameter int WarpWidth  = 4,
    parameter int PcWidth    = 16,
    parameter int StackDepth = 4,
    parameter int WidWidth   = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          init_i,
    input  logic [WidWidth-1:0]           init_wid_i,
    input  logic [WarpWidth-1:0]          init_mask_i,
    input  logic                          bru_branch_i,
    input  logic [WidWidth-1:0]           bru_branch_wid_i,
    input  logic [WarpWidth-1:0]          bru_branching_mask_i,
    input  logic [PcWidth-1:0]            bru_inactive_pc_i,
    input  logic                          pop_valid_i,
    input  logic [WidWidth-1:0]           pop_wid_i,
    output logic                          pop_ready_o,
    output logic [NumWarps*WarpWidth-1:0] act_mask_o,
    output logic                          redirect_valid_o,
    output logic [WidWidth-1:0]           redirect_wid_o,
    output logic [PcWidth-1:0]            redirect_pc_o,
    output logic [WarpWidth-1:0]          redirect_mask_o,
    output logic                          warp_done_o,
    output logic [WidWidth-1:0]           warp_done_wid_o,
    output logic                          overflow_o
);

    localparam int SpW  = $clog2(StackDepth + 1);
    localparam int IdxW = StackDepth > 1 ? $clog2(StackDepth) : 1;
    localparam logic [SpW-1:0] SpFull = SpW'(StackDepth);

    logic [NumWarps-1:0][WarpWidth-1:0] act_q, act_d;
    logic [NumWarps-1:0][SpW-1:0]       sp_q, sp_d;
    logic [PcWidth-1:0]   stk_pc_q   [NumWarps][StackDepth];
    logic [WarpWidth-1:0] stk_mask_q [NumWarps][StackDepth];

    logic                 rv_q, rv_d;
    logic [WidWidth-1:0]  rwid_q, rwid_d;
    logic [PcWidth-1:0]   rpc_q, rpc_d;
    logic [WarpWidth-1:0] rmask_q, rmask_d;
    logic                 done_q, done_d;
    logic [WidWidth-1:0]  dwid_q, dwid_d;

    logic                 br_live, br_redir, br_push, push_en;
    logic                 pop_block, pop_acc;
    logic [WarpWidth-1:0] br_t, br_n;
    logic [SpW-1:0]       br_sp, pop_sp, pop_sp_m1;
    logic [IdxW-1:0]      push_idx, pop_idx;

    // Init on the same warp overrides the branch entirely
    assign br_t     = bru_branching_mask_i;
    assign br_n     = act_q[bru_branch_wid_i] & ~br_t;
    assign br_sp    = sp_q[bru_branch_wid_i];
    assign br_live  = bru_branch_i &&
                      !(init_i && init_wid_i == bru_branch_wid_i);
    assign br_redir = br_live && br_t == '0 && br_n != '0;
    assign br_push  = br_live && br_t != '0 && br_n != '0;
    assign push_en  = br_push && br_sp != SpFull;
    assign push_idx = br_sp[IdxW-1:0];

    assign pop_sp    = sp_q[pop_wid_i];
    assign pop_sp_m1 = pop_sp - SpW'(1);
    assign pop_idx   = pop_sp_m1[IdxW-1:0];

    // Pop stalls on same-warp init/branch, or when it would collide with a branch redirect
    assign pop_block = (init_i && init_wid_i == pop_wid_i) ||
                       (bru_branch_i && bru_branch_wid_i == pop_wid_i) ||
                       (br_redir && pop_sp != '0);
    assign pop_ready_o = !pop_block;
    assign pop_acc     = pop_valid_i && !pop_block;

    always_comb begin
        act_d   = act_q;
        sp_d    = sp_q;
        rv_d    = 1'b0;
        rwid_d  = rwid_q;
        rpc_d   = rpc_q;
        rmask_d = rmask_q;
        done_d  = 1'b0;
        dwid_d  = dwid_q;
        if (pop_acc) begin
            if (pop_sp != '0) begin
                sp_d[pop_wid_i]  = pop_sp_m1;
                act_d[pop_wid_i] = stk_mask_q[pop_wid_i][pop_idx];
                rv_d    = 1'b1;
                rwid_d  = pop_wid_i;
                rpc_d   = stk_pc_q[pop_wid_i][pop_idx];
                rmask_d = stk_mask_q[pop_wid_i][pop_idx];
            end else begin
                act_d[pop_wid_i] = '0;
                done_d = 1'b1;
                dwid_d = pop_wid_i;
            end
        end
        if (br_push) begin
            act_d[bru_branch_wid_i] = br_t;
            if (push_en) begin
                sp_d[bru_branch_wid_i] = br_sp + SpW'(1);
            end
        end
        if (br_redir) begin
            act_d[bru_branch_wid_i] = br_n;
            rv_d    = 1'b1;
            rwid_d  = bru_branch_wid_i;
            rpc_d   = bru_inactive_pc_i;
            rmask_d = br_n;
        end
        if (init_i) begin
            act_d[init_wid_i] = init_mask_i;
            sp_d[init_wid_i]  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_q   <= '0;
            sp_q    <= '0;
            rv_q    <= 1'b0;
            rwid_q  <= '0;
            rpc_q   <= '0;
            rmask_q <= '0;
            done_q  <= 1'b0;
            dwid_q  <= '0;
        end else begin
            act_q   <= act_d;
            sp_q    <= sp_d;
            rv_q    <= rv_d;
            rwid_q  <= rwid_d;
            rpc_q   <= rpc_d;
            rmask_q <= rmask_d;
            done_q  <= done_d;
            dwid_q  <= dwid_d;
        end
    end

    // Entry contents need no reset; sp alone decides validity
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            stk_pc_q[bru_branch_wid_i][push_idx]   <= bru_inactive_pc_i;
            stk_mask_q[bru_branch_wid_i][push_idx] <= br_n;
        end
    end

`ifdef DIVSTACK_OVERFLOW_FLAG_EN
    logic ovf_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (br_push && br_sp == SpFull) begin
            ovf_q <= 1'b1;
            $error("divergence_stack: push dropped on warp %0d",
                   bru_branch_wid_i);
        end
    end
    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

    assign act_mask_o       = act_q;
    assign redirect_valid_o = rv_q;
    assign redirect_wid_o   = rwid_q;
    assign redirect_pc_o    = rpc_q;
    assign redirect_mask_o  = rmask_q;
    assign warp_done_o      = done_q;
    assign warp_done_wid_o  = dwid_q;

endmodule
